// File: rtl/oldland_regfile_pkg.sv
// oldland_regfile_pkg: shared state encoding and default geometry for the register file.
package oldland_regfile_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_BITS = 4;
endpackage

// File: rtl/oldland_regfile_ram.sv
// oldland_regfile_ram: 1-write/2-read synchronous RAM, registered read-before-write outputs, no reset.
module oldland_regfile_ram
    import oldland_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]  raddr_a,
    input  logic [ADDR_BITS-1:0]  raddr_b,
    output logic [DATA_WIDTH-1:0] qa,
    output logic [DATA_WIDTH-1:0] qb
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        qa <= mem[raddr_a];
        qb <= mem[raddr_b];
    end
endmodule

// File: rtl/oldland_regfile_mp.sv
// oldland_regfile_mp: 2R/1W register file with sequential clear, optional bypass and a debug port.
module oldland_regfile_mp
    import oldland_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  ra_sel,
    input  logic [ADDR_BITS-1:0]  rb_sel,
    input  logic [ADDR_BITS-1:0]  rd_sel,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_val,
    output logic [DATA_WIDTH-1:0] ra,
    output logic [DATA_WIDTH-1:0] rb,
    output logic                  busy,
    input  logic                  dbg_en,
    input  logic                  dbg_req,
    input  logic                  dbg_wr,
    input  logic [ADDR_BITS-1:0]  dbg_reg_sel,
    input  logic [DATA_WIDTH-1:0] dbg_reg_wr_val,
    output logic [DATA_WIDTH-1:0] dbg_reg_val,
    output logic                  dbg_ack
);
    state_t state;
    logic [ADDR_BITS-1:0] clr_idx, a_sel, w_sel, ram_waddr;
    logic [DATA_WIDTH-1:0] w_val, wv_q, ram_wdata, qa, qb, a_data, hold;
    logic run, clr, we, ram_we, rd_ok, byp_a, byp_b, dbg_wr_q;

    always_comb begin
        run = state == RUN && !rst;
        clr = state == CLEAR && !rst;
        a_sel = dbg_en ? dbg_reg_sel : ra_sel;
        w_sel = dbg_en ? dbg_reg_sel : rd_sel;
        w_val = dbg_en ? dbg_reg_wr_val : wr_val;
        we = run && (dbg_en ? dbg_req && dbg_wr : wr_en);
        ram_we = clr || we;
        ram_waddr = clr ? clr_idx : w_sel;
        ram_wdata = clr ? '0 : w_val;
        a_data = byp_a ? wv_q : qa;
        ra = rd_ok ? a_data : '0;
        rb = rd_ok ? (byp_b ? wv_q : qb) : '0;
        // debug writes always echo the written value, independent of BYPASS
        dbg_reg_val = dbg_ack ? (dbg_wr_q ? wv_q : a_data) : hold;
        busy = state == CLEAR;
    end

    oldland_regfile_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(ADDR_BITS)) u_ram (
        .clk(clk),
        .we(ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr_a(a_sel),
        .raddr_b(rb_sel),
        .qa(qa),
        .qb(qb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            clr_idx <= '0;
            rd_ok <= 1'b0;
            dbg_ack <= 1'b0;
            dbg_wr_q <= 1'b0;
            byp_a <= 1'b0;
            byp_b <= 1'b0;
            hold <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (&clr_idx) state <= RUN;
            end
            rd_ok <= state == RUN;
            dbg_ack <= state == RUN && dbg_en && dbg_req;
            dbg_wr_q <= dbg_wr;
            byp_a <= BYPASS != 0 && we && w_sel == a_sel;
            byp_b <= BYPASS != 0 && we && w_sel == rb_sel;
            hold <= dbg_reg_val;
        end
    end

    always_ff @(posedge clk) wv_q <= w_val;
endmodule

// File: tb/tb_oldland_regfile_mp.sv
// tb_oldland_regfile_mp: three configurations share one stimulus stream; a cycle model feeds a
// scoreboard queue that a negedge monitor drains and compares.
module tb_oldland_regfile_mp;
    typedef struct {
        int d;
        logic busy;
        logic ack;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] dv;
    } exp_t;

    logic clk = 0;
    logic rst, wr_en, dbg_en, dbg_req, dbg_wr;
    logic [4:0] ra_sel, rb_sel, rd_sel, dbg_reg_sel;
    logic [63:0] wr_val, dbg_reg_wr_val;
    logic [31:0] ra0, rb0, dv0, ra1, rb1, dv1;
    logic [63:0] ra2, rb2, dv2;
    logic busy0, busy1, busy2, ack0, ack1, ack2;

    exp_t q[$];
    int total = 0, bad = 0;
    bit armed = 0;
    int abw[3] = '{4, 4, 5};
    int byp[3] = '{1, 0, 1};
    logic [63:0] dwm[3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] m[3][32];
    logic [63:0] hold_m[3];
    bit busy_m[3];
    int cnt_m[3];

    always #5 clk = ~clk;

    oldland_regfile_mp #(.DATA_WIDTH(32), .ADDR_BITS(4), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .ra_sel(ra_sel[3:0]), .rb_sel(rb_sel[3:0]), .rd_sel(rd_sel[3:0]),
        .wr_en(wr_en), .wr_val(wr_val[31:0]), .ra(ra0), .rb(rb0), .busy(busy0), .dbg_en(dbg_en),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_reg_sel(dbg_reg_sel[3:0]),
        .dbg_reg_wr_val(dbg_reg_wr_val[31:0]), .dbg_reg_val(dv0), .dbg_ack(ack0));
    oldland_regfile_mp #(.DATA_WIDTH(32), .ADDR_BITS(4), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .ra_sel(ra_sel[3:0]), .rb_sel(rb_sel[3:0]), .rd_sel(rd_sel[3:0]),
        .wr_en(wr_en), .wr_val(wr_val[31:0]), .ra(ra1), .rb(rb1), .busy(busy1), .dbg_en(dbg_en),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_reg_sel(dbg_reg_sel[3:0]),
        .dbg_reg_wr_val(dbg_reg_wr_val[31:0]), .dbg_reg_val(dv1), .dbg_ack(ack1));
    oldland_regfile_mp #(.DATA_WIDTH(64), .ADDR_BITS(5), .BYPASS(1)) u2 (
        .clk(clk), .rst(rst), .ra_sel(ra_sel), .rb_sel(rb_sel), .rd_sel(rd_sel),
        .wr_en(wr_en), .wr_val(wr_val), .ra(ra2), .rb(rb2), .busy(busy2), .dbg_en(dbg_en),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_reg_sel(dbg_reg_sel),
        .dbg_reg_wr_val(dbg_reg_wr_val), .dbg_reg_val(dv2), .dbg_ack(ack2));

    // spec-level model: computes what each DUT must show after the edge just taken
    task automatic model(int d);
        int n, a, b, w;
        logic we;
        logic [63:0] wv;
        exp_t e;
        n = 1 << abw[d];
        a = int'(dbg_en ? dbg_reg_sel : ra_sel) & (n - 1);
        b = int'(rb_sel) & (n - 1);
        w = int'(dbg_en ? dbg_reg_sel : rd_sel) & (n - 1);
        wv = (dbg_en ? dbg_reg_wr_val : wr_val) & dwm[d];
        e.d = d;
        e.ra = 0;
        e.rb = 0;
        e.ack = 0;
        if (rst) begin
            busy_m[d] = 1;
            cnt_m[d] = 0;
            hold_m[d] = 0;
        end else if (busy_m[d]) begin
            m[d][cnt_m[d]] = 0;
            cnt_m[d]++;
            busy_m[d] = cnt_m[d] < n;
        end else begin
            we = dbg_en ? (dbg_req && dbg_wr) : wr_en;
            e.ra = (we && w == a && byp[d] == 1) ? wv : m[d][a];
            e.rb = (we && w == b && byp[d] == 1) ? wv : m[d][b];
            if (dbg_en && dbg_req) begin
                e.ack = 1;
                hold_m[d] = dbg_wr ? wv : e.ra;
            end
            if (we) m[d][w] = wv;
        end
        e.busy = busy_m[d];
        e.dv = hold_m[d];
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) armed = 1;
        if (armed) for (int d = 0; d < 3; d++) model(d);
        #1;
    endtask

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h", nm, d, act, want);
        end
    endtask

    function automatic exp_t actual(int d);
        exp_t a;
        a.d = d;
        case (d)
            0: begin a.busy = busy0; a.ack = ack0; a.ra = {32'h0, ra0}; a.rb = {32'h0, rb0}; a.dv = {32'h0, dv0}; end
            1: begin a.busy = busy1; a.ack = ack1; a.ra = {32'h0, ra1}; a.rb = {32'h0, rb1}; a.dv = {32'h0, dv1}; end
            default: begin a.busy = busy2; a.ack = ack2; a.ra = ra2; a.rb = rb2; a.dv = dv2; end
        endcase
        return a;
    endfunction

    always @(negedge clk) begin
        exp_t e, a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.d);
            chk("busy", e.d, {63'h0, a.busy}, {63'h0, e.busy});
            chk("dbg_ack", e.d, {63'h0, a.ack}, {63'h0, e.ack});
            chk("ra", e.d, a.ra, e.ra);
            chk("rb", e.d, a.rb, e.rb);
            chk("dbg_reg_val", e.d, a.dv, e.dv);
        end
    end

    task automatic idle();
        wr_en = 0; dbg_en = 0; dbg_req = 0; dbg_wr = 0;
        ra_sel = 0; rb_sel = 0; rd_sel = 0; dbg_reg_sel = 0;
        wr_val = 0; dbg_reg_wr_val = 0;
    endtask

    task automatic rnd();
        rst = ($urandom % 150) == 0;
        ra_sel = 5'($urandom); rb_sel = 5'($urandom); rd_sel = 5'($urandom);
        dbg_reg_sel = 5'($urandom);
        wr_en = 1'($urandom); dbg_req = 1'($urandom); dbg_wr = 1'($urandom);
        if (($urandom % 16) == 0) dbg_en = ~dbg_en;
        wr_val = {$urandom, $urandom};
        dbg_reg_wr_val = {$urandom, $urandom};
    endtask

    initial begin
        idle();
        rst = 1; tick(); tick(); rst = 0;
        repeat (34) tick();
        wr_en = 1; rd_sel = 5; wr_val = 64'hDEADBEEF; tick(); wr_en = 0;
        ra_sel = 5; tick(); tick();
        rst = 1; tick(); rst = 0;
        repeat (34) tick();
        ra_sel = 5; rb_sel = 5; tick(); tick();
        wr_en = 1; rd_sel = 3; wr_val = 64'h12345678; tick(); wr_en = 0;
        ra_sel = 3; rb_sel = 3; tick(); tick();
        wr_en = 1; rd_sel = 7; wr_val = 64'hA5A5A5A5; ra_sel = 7; rb_sel = 2; tick(); wr_en = 0; tick();
        dbg_en = 1; dbg_req = 1; dbg_wr = 1; dbg_reg_sel = 9; dbg_reg_wr_val = 64'hCAFEF00D; tick();
        dbg_wr = 0; tick();
        dbg_req = 0; wr_en = 1; rd_sel = 9; wr_val = 64'h1111; tick();
        wr_en = 0; dbg_req = 1; tick();
        dbg_req = 0; tick(); dbg_en = 0; rb_sel = 9; tick(); tick();
        rst = 1; tick(); rst = 0;
        wr_en = 1; dbg_en = 1; dbg_req = 1; dbg_wr = 1;
        repeat (8) tick();
        rst = 1; tick(); rst = 0;
        repeat (34) tick();
        idle();
        wr_en = 1; rd_sel = 31; wr_val = 64'hFFFF_0000_FFFF_0000; tick(); wr_en = 0;
        ra_sel = 31; rb_sel = 31; tick(); tick();
        repeat (600) begin rnd(); tick(); end
        idle(); rst = 0;
        tick();
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
